// File: rtl/alu_seq.sv
// alu_seq: registered, multi-cycle ALU with a start/busy/done handshake.
//
// Ports
//   clk      system clock; all state changes on the rising edge
//   rst      synchronous, active-high reset; overrides everything
//   start    request, accepted on a rising edge where busy=0
//   op_mode  operation select, latched on accept
//   datain1  operand A, latched on accept
//   datain2  operand B, latched on accept
//   out      2*WIDTH result register, held until the next completion
//   busy     high while MUL or DIV is iterating
//   done     one-cycle pulse on the cycle after out is written
//   flags    {err, ovf, carry, zero}; exists only when ALU_FLAGS_EN is defined
//
// Handshake: start acts as "valid" and !busy as "ready". A request is taken
// on any rising edge where start=1 and busy=0. This includes the cycle where
// done=1, so a held start issues back-to-back operations. Single-cycle ops
// write out and raise done on the accepting edge. MUL and DIV (B!=0) hold
// busy for WIDTH cycles, then write out and raise done.
//
// Optional build macro: ALU_FLAGS_EN adds the registered flags output.
module alu_seq #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         op_mode,
    input  logic [WIDTH-1:0]   datain1,
    input  logic [WIDTH-1:0]   datain2,
    output logic [2*WIDTH-1:0] out,
    output logic               busy,
    output logic               done
`ifdef ALU_FLAGS_EN
    ,
    output logic [3:0]         flags
`endif
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_DIV = 4'b1001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic [3:0]         op_q, op_nxt;
    logic [WIDTH-1:0]   a_q, a_nxt, b_q, b_nxt;
    logic [WIDTH-1:0]   acc_hi, hi_nxt, acc_lo, lo_nxt;
    logic [2*WIDTH-1:0] out_nxt;
    logic               done_nxt;

    // Single-cycle results, computed straight from the inputs on the accepting edge
    logic [WIDTH:0]     sum, dif;
    logic [2*WIDTH-1:0] sc_res;
    logic               is_multi;

    assign sum      = {1'b0, datain1} + {1'b0, datain2};
    assign dif      = {1'b0, datain1} - {1'b0, datain2};   // bit WIDTH is the borrow
    assign is_multi = (op_mode == OP_MUL) || ((op_mode == OP_DIV) && (datain2 != '0));

    always_comb begin
        sc_res = '0;
        case (op_mode)
            OP_ADD:  sc_res = {{(WIDTH-1){1'b0}}, sum};
            OP_SUB:  sc_res = {{(WIDTH-1){1'b0}}, dif};
            OP_AND:  sc_res = {{WIDTH{1'b0}}, datain1 & datain2};
            OP_OR:   sc_res = {{WIDTH{1'b0}}, datain1 | datain2};
            OP_XOR:  sc_res = {{WIDTH{1'b0}}, datain1 ^ datain2};
            OP_NOT:  sc_res = {{WIDTH{1'b0}}, ~datain1};
            OP_SHL:  sc_res = {{(WIDTH-1){1'b0}}, datain1, 1'b0};
            OP_SHR:  sc_res = {{WIDTH{1'b0}}, 1'b0, datain1[WIDTH-1:1]};
            // Only reached with B==0: quotient all ones, remainder A
            OP_DIV:  sc_res = {datain1, {WIDTH{1'b1}}};
            OP_CMP:  sc_res = {{(2*WIDTH-3){1'b0}}, (datain1 < datain2),
                               (datain1 == datain2), (datain1 > datain2)};
            OP_NOP:  sc_res = out;
            default: sc_res = '0;   // reserved codes
        endcase
    end

    // One iteration of the multi-cycle datapath.
    // MUL: {acc_hi, acc_lo} starts as {0, B}; add A into the high half when the
    //      multiplier LSB is set, then shift the whole pair right by one.
    // DIV: acc_lo starts as A (becomes the quotient), acc_hi is the partial
    //      remainder; shift left, subtract B when it fits (restoring).
    logic [WIDTH:0]   madd, dshift;
    logic             dge;
    logic [WIDTH-1:0] step_hi, step_lo;

    assign madd   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
    assign dshift = {acc_hi, acc_lo[WIDTH-1]};
    assign dge    = (dshift >= {1'b0, b_q});

    always_comb begin
        if (op_q == OP_MUL) begin
            step_hi = madd[WIDTH:1];
            step_lo = {madd[0], acc_lo[WIDTH-1:1]};
        end else begin
            // When dge, dshift-B < B, so the low WIDTH bits hold the full difference
            step_hi = dge ? (dshift[WIDTH-1:0] - b_q) : dshift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], dge};
        end
    end

    // Next-state / next-output logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        op_nxt    = op_q;
        a_nxt     = a_q;
        b_nxt     = b_q;
        hi_nxt    = acc_hi;
        lo_nxt    = acc_lo;
        out_nxt   = out;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    op_nxt = op_mode;
                    a_nxt  = datain1;
                    b_nxt  = datain2;
                    if (is_multi) begin
                        state_nxt = CALC;
                        cnt_nxt   = '0;
                        hi_nxt    = '0;
                        lo_nxt    = (op_mode == OP_MUL) ? datain2 : datain1;
                    end else begin
                        out_nxt  = sc_res;
                        done_nxt = 1'b1;
                    end
                end
            end
            CALC: begin
                hi_nxt  = step_hi;
                lo_nxt  = step_lo;
                cnt_nxt = cnt + 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    out_nxt   = {step_hi, step_lo};
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            out    <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            op_q   <= op_nxt;
            a_q    <= a_nxt;
            b_q    <= b_nxt;
            acc_hi <= hi_nxt;
            acc_lo <= lo_nxt;
            out    <= out_nxt;
            done   <= done_nxt;
        end
    end

    assign busy = (state == CALC);

`ifdef ALU_FLAGS_EN
    logic [3:0] flags_nxt;
    logic       f_err, f_ovf, f_carry;

    // Flags follow the value being written into out, so they change only with done
    always_comb begin
        f_err     = 1'b0;
        f_ovf     = 1'b0;
        f_carry   = 1'b0;
        flags_nxt = flags;
        if (done_nxt) begin
            if (state == CALC) begin
                f_ovf = (op_q == OP_MUL) && (out_nxt[2*WIDTH-1:WIDTH] != '0);
            end else begin
                case (op_mode)
                    OP_ADD, OP_SUB, OP_SHL:         f_carry = out_nxt[WIDTH];
                    OP_DIV:                         f_err   = 1'b1;   // single-cycle DIV means B==0
                    4'b1011, 4'b1100, 4'b1101, 4'b1110: f_err = 1'b1;
                    default: ;
                endcase
            end
            flags_nxt = {f_err, f_ovf, f_carry, (out_nxt == '0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) flags <= '0;
        else     flags <= flags_nxt;
    end
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq (WIDTH=4): directed vectors with literal expectations,
// plus a transaction-level reference model compared against the DUT every cycle.
module tb_alu_seq;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [3:0]     op_mode;
    logic [W-1:0]   datain1, datain2;
    logic [2*W-1:0] out;
    logic           busy, done;
`ifdef ALU_FLAGS_EN
    logic [3:0]     flags;
`endif

    alu_seq #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op_mode (op_mode),
        .datain1 (datain1),
        .datain2 (datain2),
        .out     (out),
        .busy    (busy),
        .done    (done)
`ifdef ALU_FLAGS_EN
        ,
        .flags   (flags)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        n_tests++;
        if (got !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [2*W-1:0] ref_res(input int op, input int a, input int b,
                                               input logic [2*W-1:0] cur);
        int mask = (1 << W) - 1;
        int r;
        case (op)
            0:  r = a + b;
            1:  r = ((a - b) & mask) | ((a < b) ? (1 << W) : 0);
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = (~a) & mask;
            6:  r = a << 1;
            7:  r = a >> 1;
            8:  r = a * b;
            9:  r = (b == 0) ? ((a << W) | mask) : (((a % b) << W) | (a / b));
            10: r = ((a < b) ? 4 : 0) + ((a == b) ? 2 : 0) + ((a > b) ? 1 : 0);
            15: r = int'(cur);
            default: r = 0;
        endcase
        return r[2*W-1:0];
    endfunction

`ifdef ALU_FLAGS_EN
    function automatic logic [3:0] ref_flags(input int op, input int b, input logic [2*W-1:0] res);
        logic z, c, o, e;
        z = (res == 0);
        c = (op == 0 || op == 1 || op == 6) ? res[W] : 1'b0;
        o = (op == 8) && ((res >> W) != 0);
        e = (op == 9 && b == 0) || (op >= 11 && op <= 14);
        return {e, o, c, z};
    endfunction
    logic [3:0] m_flags = '0, m_pend_f = '0;
`endif

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] m_out  = '0;
    logic [2*W-1:0] m_pend = '0;
    logic           m_done = 1'b0;
    int             m_left = 0;   // cycles of busy still to come

    always @(posedge clk) begin
        logic [2*W-1:0] res;
        cyc++;
        m_done = 1'b0;
        if (rst) begin
            m_left = 0;
            m_out  = '0;
            exp_q.delete();
`ifdef ALU_FLAGS_EN
            m_flags = '0;
`endif
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_out  = m_pend;
                m_done = 1'b1;
`ifdef ALU_FLAGS_EN
                m_flags = m_pend_f;
`endif
            end
        end else if (start) begin
            res = ref_res(int'(op_mode), int'(datain1), int'(datain2), m_out);
            exp_q.push_back(res);
            if (op_mode == 4'd8 || (op_mode == 4'd9 && datain2 != 0)) begin
                m_left = W;
                m_pend = res;
`ifdef ALU_FLAGS_EN
                m_pend_f = ref_flags(int'(op_mode), int'(datain2), res);
`endif
            end else begin
                m_out  = res;
                m_done = 1'b1;
`ifdef ALU_FLAGS_EN
                m_flags = ref_flags(int'(op_mode), int'(datain2), res);
`endif
            end
        end
    end

    // ---------------- compare process / scoreboard ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", busy, (m_left > 0));
            check("done", done, m_done);
            check("out", out, m_out);
`ifdef ALU_FLAGS_EN
            check("flags", flags, m_flags);
`endif
            if (done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_empty: done with out=%0h but no request outstanding", out);
                end else begin
                    check("sb_out", out, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+2; returns at posedge+2 of the cycle after the accept edge
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start   = 1'b1;
        op_mode = op;
        datain1 = a;
        datain2 = b;
        @(posedge clk);
        #2;
        start   = 1'b0;
        op_mode = 4'($urandom_range(0, 15));
        datain1 = W'($urandom_range(0, 15));
        datain2 = W'($urandom_range(0, 15));
    endtask

    task automatic wait_done(output int bc, output int t);
        bc = 0;
        t  = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                t = cyc;
                @(posedge clk);
                #2;
                return;
            end
            if (busy === 1'b1) bc++;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_done: no done within 40 cycles");
        @(posedge clk);
        #2;
    endtask

    task automatic run_vec(input string name, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [7:0] exp_v, input int exp_bc);
        int bc, t;
        issue(op, a, b);
        wait_done(bc, t);
        check(name, out, exp_v);
        check({name, "_busy_cycles"}, bc, exp_bc);
    endtask

`ifdef ALU_FLAGS_EN
    task automatic check_flags(input string name, input logic [3:0] exp_v);
        check(name, flags, exp_v);
    endtask
`endif

    // ---------------- directed stimulus ----------------
    initial begin
        int bc, bc0, t1, t2;
        rst = 1'b1; start = 1'b0; op_mode = '0; datain1 = '0; datain2 = '0;
        repeat (2) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_out", out, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
`ifdef ALU_FLAGS_EN
        check_flags("rst_flags", 4'b0000);
`endif
        @(posedge clk);
        #2;

        run_vec("add_3_2", 4'b0000, 4'd3, 4'd2, 8'h05, 0);
`ifdef ALU_FLAGS_EN
        check_flags("add_3_2_flags", 4'b0000);
`endif
        run_vec("sub_2_3", 4'b0001, 4'd2, 4'd3, 8'h1F, 0);
`ifdef ALU_FLAGS_EN
        check_flags("sub_2_3_flags", 4'b0010);
`endif
        run_vec("sub_3_3", 4'b0001, 4'd3, 4'd3, 8'h00, 0);
`ifdef ALU_FLAGS_EN
        check_flags("sub_3_3_flags", 4'b0001);
`endif

        // MUL 15*15 with a start pulse (A=1) during busy that must be ignored
        issue(4'b1000, 4'd15, 4'd15);
        start = 1'b1; op_mode = 4'b1000; datain1 = 4'd1; datain2 = 4'd1;
        @(negedge clk);
        bc0 = (busy === 1'b1) ? 1 : 0;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(bc, t1);
        check("mul_15_15", out, 8'hE1);
        check("mul_15_15_busy_cycles", bc0 + bc, 4);
`ifdef ALU_FLAGS_EN
        check_flags("mul_15_15_flags", 4'b0100);
`endif

        run_vec("div_13_4", 4'b1001, 4'd13, 4'd4, 8'h13, 4);
        run_vec("div_7_0", 4'b1001, 4'd7, 4'd0, 8'h7F, 0);
`ifdef ALU_FLAGS_EN
        check_flags("div_7_0_flags", 4'b1000);
`endif

        // Remaining ops, hand-computed
        run_vec("and", 4'b0010, 4'hC, 4'hA, 8'h08, 0);
        run_vec("or", 4'b0011, 4'hC, 4'hA, 8'h0E, 0);
        run_vec("xor", 4'b0100, 4'hC, 4'hA, 8'h06, 0);
        run_vec("not", 4'b0101, 4'h5, 4'h0, 8'h0A, 0);
        run_vec("shl", 4'b0110, 4'h9, 4'h0, 8'h12, 0);
        run_vec("shr", 4'b0111, 4'h9, 4'h0, 8'h04, 0);
        run_vec("cmp_lt", 4'b1010, 4'd5, 4'd9, 8'h04, 0);
        run_vec("cmp_eq", 4'b1010, 4'd7, 4'd7, 8'h02, 0);
        run_vec("cmp_gt", 4'b1010, 4'd9, 4'd5, 8'h01, 0);
        run_vec("add_carry", 4'b0000, 4'd15, 4'd1, 8'h10, 0);
        run_vec("nop_hold", 4'b1111, 4'd3, 4'd3, 8'h10, 0);
        run_vec("sub_0_1", 4'b0001, 4'd0, 4'd1, 8'h1F, 0);
        run_vec("reserved", 4'b1100, 4'd5, 4'd5, 8'h00, 0);
        run_vec("mul_3_5", 4'b1000, 4'd3, 4'd5, 8'h0F, 4);
        run_vec("div_15_15", 4'b1001, 4'd15, 4'd15, 8'h01, 4);
        run_vec("div_0_3", 4'b1001, 4'd0, 4'd3, 8'h00, 4);
        run_vec("div_15_2", 4'b1001, 4'd15, 4'd2, 8'h17, 4);

        // Back-to-back: start held high through a MUL 3*2
        start = 1'b1; op_mode = 4'b1000; datain1 = 4'd3; datain2 = 4'd2;
        @(posedge clk);
        #2;
        wait_done(bc, t1);   // returns just after the edge that accepts the second op
        start = 1'b0;
        check("b2b_first", out, 8'h06);
        wait_done(bc, t2);
        check("b2b_second", out, 8'h06);
        check("b2b_spacing", t2 - t1, 5);

        // Reset on the second busy cycle of MUL 9*9
        issue(4'b1000, 4'd9, 4'd9);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_out", out, 8'h00);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_done", done, 1'b0);
`ifdef ALU_FLAGS_EN
        check_flags("rst_mid_flags", 4'b0000);
`endif
        @(posedge clk);
        #2;
        run_vec("add_after_rst", 4'b0000, 4'd1, 4'd1, 8'h02, 0);

        repeat (3) @(posedge clk);
        check("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU.
- Adds a start/busy/done handshake, operand latching, and multi-cycle shift-add multiply and restoring divide.
- Adds a compare op and optional status flags.
- Sits between the register file and the writeback path of the CPU datapath. It is driven by the control unit's op_mode.

Parameters:
- WIDTH, 4, operand width in bits. Result width is 2*WIDTH. Legal values are 2..16.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only while busy=0.
- op_mode  in  4  operation select; latched on accept.
- datain1  in  WIDTH  operand A; latched on accept.
- datain2  in  WIDTH  operand B; latched on accept.
- out  out  2*WIDTH  registered result; held until the next completion.
- busy  out  1  high while a multi-cycle op is iterating.
- done  out  1  one-cycle pulse when out is updated.
- flags  out  4  {err, ovf, carry, zero}; present only with ALU_FLAGS_EN.

Behaviour:
- Reset: out=0, busy=0, done=0, flags=0, state=IDLE, iteration counter=0.
- Reset takes priority over everything. A reset during MUL or DIV aborts the operation and produces no done.
- States:
  - IDLE: start=1 means accept. A single-cycle op goes to IDLE and writes out with done=1 on the same edge. MUL, or DIV with B!=0, goes to CALC with busy=1.
  - CALC: counter runs 0..WIDTH-1, one iteration per edge. On the edge with counter=WIDTH-1: write out, done=1, busy=0, return to IDLE.
- Latency, counted from the accepting edge:
  - Single-cycle ops: done visible in the following cycle.
  - MUL/DIV: busy high for exactly WIDTH cycles; done asserted WIDTH cycles after the single-cycle case.
- done is asserted only for one cycle. start is ignored whenever busy=1. start may be asserted in the cycle where done=1 (busy=0) and is then accepted.
- op_mode encoding (unsigned arithmetic; results zero-extended to 2*WIDTH unless stated):
  - 0000 ADD: out[WIDTH:0] = A+B. out[WIDTH] is the carry.
  - 0001 SUB: out[WIDTH-1:0] = A-B mod 2^WIDTH. out[WIDTH] = borrow (A<B).
  - 0010 AND; 0011 OR; 0100 XOR.
  - 0101 NOT A.
  - 0110 SHL A by 1: out[WIDTH:0] = {A,0}.
  - 0111 SHR A by 1.
  - 1000 MUL: full 2*WIDTH product, shift-add, WIDTH iterations.
  - 1001 DIV: out = {remainder, quotient}, restoring division, WIDTH iterations.
  - 1010 CMP: out[2:0] = {A<B, A==B, A>B}.
  - 1111 NOP: out unchanged, done still pulses.
  - 1011..1110 reserved: out=0, err=1, single-cycle.
- Divide by zero:
  - Completes single-cycle; no CALC entry, busy stays 0.
  - quotient = all ones, remainder = A, err=1.
- Operands and op_mode are taken from the latched copies only. Input changes after the accept edge do not affect the result.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: the flags port exists and is registered, updated only with done.
  - zero = (out==0).
  - carry = out[WIDTH] for ADD/SUB/SHL, else 0.
  - ovf = MUL product exceeds WIDTH bits, else 0.
  - err = divide by zero or reserved op.
  - flags are reset to 0.
- Undefined: the flags port and all flag logic are absent. All other behaviour is identical.

Test Plan (WIDTH=4):
- ADD: A=3, B=2, start for one cycle -> next cycle done=1, out=8'h05, busy never high, flags zero=0 carry=0.
- SUB: A=2, B=3 -> out=8'h1F (borrow bit 4 set, low nibble F), carry=1. Then SUB A=3, B=3 -> out=8'h00, zero=1.
- MUL: A=15, B=15 -> busy high exactly 4 cycles, then done with out=8'hE1, ovf=1. Pulsing start with A=1 while busy -> ignored; result unchanged.
- DIV: A=13, B=4 -> after 4 busy cycles out=8'h13 (rem 1, quot 3). DIV A=7, B=0 -> single-cycle done, out=8'h7F, err=1, busy stays 0.
- Back-to-back: start held high through a MUL 3*2 -> second op accepted in the done cycle. Results 8'h06 then 8'h06, with done pulses 5 cycles apart.
- Reset mid-op: MUL 9*9 started, rst asserted on the 2nd busy cycle -> next cycle out=0, busy=0, done=0, flags=0. A following ADD 1+1 -> out=8'h02.
